// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = 3;
  localparam logic [DIV_WIDTH-1:0] DIV_Q_ZERO = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: true subtraction T - {0,D} with carry-out as no-borrow.
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_t,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_s,
  output logic             o_no_borrow
);

  logic [WIDTH+1:0] w_sum;

  // Invert D and add a carry-in of 1; the extra top bit is the carry-out.
  assign w_sum       = {1'b0, i_t} + {1'b0, 1'b1, ~i_d} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign o_s         = w_sum[WIDTH:0];
  assign o_no_borrow = w_sum[WIDTH+1];

endmodule

// File: rtl/div_seq_8bit.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Optional divide-by-zero short cut and error flag: define DIVZERO_DETECT_EN.
module div_seq_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_err
);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_s;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH:0]   w_r_next;
  logic             w_accept;
  logic             w_zero_trap;

  assign w_t      = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_q_next = {r_q[WIDTH-2:0], w_no_borrow};
  assign w_r_next = w_no_borrow ? w_s : w_t;
  assign w_accept = (r_state == IDLE) && start;

  div_sub_stage #(.WIDTH(WIDTH)) u_stage (
    .i_t        (w_t),
    .i_d        (r_d),
    .o_s        (w_s),
    .o_no_borrow(w_no_borrow)
  );

`ifdef DIVZERO_DETECT_EN
  logic r_div_err;

  assign w_zero_trap = w_accept && (divisor == '0);
  assign div_err     = r_div_err;

  // Error flag lives from an accepted start until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_div_err <= 1'b0;
    else if (w_accept) r_div_err <= w_zero_trap;
  end
`else
  assign w_zero_trap = 1'b0;
  assign div_err     = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = w_zero_trap ? DONE : RUN;
      RUN:     if (r_cnt == '0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_d         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_d   <= divisor;
        r_q   <= dividend;
        r_r   <= '0;
        r_cnt <= CNT_W'(WIDTH - 1);
      end
      if (w_zero_trap) begin
        r_quotient  <= DIV_Q_ZERO;
        r_remainder <= dividend;
      end
      if (r_state == RUN) begin
        r_q   <= w_q_next;
        r_r   <= w_r_next;
        r_cnt <= r_cnt - 1'b1;
        // Results are captured on the final iteration, i.e. on entry to DONE.
        if (r_cnt == '0) begin
          r_quotient  <= w_q_next;
          r_remainder <= w_r_next[WIDTH-1:0];
        end
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: doc/div_seq_8bit.md
Name: div_seq_8bit

Overview:
Multi-cycle restoring divider controller for the basic processor ALU. It sequences a single compare-subtract stage across 8 iterations to produce an 8-bit quotient and remainder. It sits beside the combinational adder/subtractor in the execute stage and is started by the control unit for DIV/MOD opcodes through a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/quotient/remainder width; the iteration count equals WIDTH
CNT_W, 3, iteration counter width (log2 WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  8  numerator; captured on accepted start
divisor  input  8  denominator; captured on accepted start
busy  output  1  high from the cycle after accept through the last RUN cycle
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  8  result; held until the next accepted start
remainder  output  8  result; held until the next accepted start
div_err  output  1  divide-by-zero flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge: state goes to IDLE; busy, done, div_err, quotient, remainder and the counter all go to 0. Reset asserted mid-operation aborts the divide with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches divisor into D.
  - Q is loaded with dividend; the 9-bit partial remainder R is cleared to 0; the counter is loaded with WIDTH-1.
  - Next state is RUN.
- RUN, one iteration per cycle:
  - T = {R[7:0], Q[7]}.
  - S = T - {1'b0, D}, a true subtraction (invert D, carry-in 1).
  - If there is no borrow (carry-out = 1): R <= S and Q <= {Q[6:0],1}.
  - Otherwise: R <= T and Q <= {Q[6:0],0}.
  - The counter decrements each cycle. Leave RUN after the iteration where the counter = 0.
- DONE:
  - done=1 for exactly one cycle.
  - quotient <= Q and remainder <= R[7:0] are registered on entry to DONE.
  - Next state is IDLE.
- Latency: start sampled at edge 0. RUN occupies cycles 1..8. done is high in cycle 9. A new start is accepted at the earliest in cycle 10 (IDLE).
- start while in RUN or DONE is ignored. There is no queueing, and operands must be re-presented.
- busy = (state==RUN). done and busy are never high together.
- Operand inputs may change freely after the accept cycle.
- Divide by zero without the feature runs the normal algorithm: quotient=8'hFF, remainder=dividend.
- Width rules:
  - The partial remainder is 9 bits. Its MSB is only a guard bit and is always 0 after a non-borrow step.
  - All arithmetic is unsigned.

Optional Feature:
Macro DIVZERO_DETECT_EN.
- Defined:
  - In IDLE, an accepted start with divisor==0 goes directly to DONE. Latency is 1 cycle: done is high in cycle 1.
  - quotient=8'hFF, remainder=dividend, div_err=1.
  - div_err is held until the next accepted start, which clears it.
- Not defined:
  - div_err is tied to 0.
  - Zero divisors take the full 9-cycle path with the results stated above.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - DIV_WIDTH=8
  - DIV_CNT_W=3
  - DIV_Q_ZERO=8'hFF
- One sub-module, div_sub_stage:
  - Combinational 9-bit compare-subtract.
  - Inputs: T, D. Outputs: S, no_borrow.
  - Instantiated once; the FSM/counter/registers live in div_seq_8bit.

Test Plan:
- Reset, then dividend=200, divisor=7, start -> done in cycle 9, quotient=28, remainder=4, busy high cycles 1..8.
- dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=77, divisor=0:
  - Macro defined: done in cycle 1, div_err=1, quotient=8'hFF, remainder=77.
  - Macro not defined: done in cycle 9, div_err=0, quotient=8'hFF, remainder=77.
- Start 100/3, pulse start with 50/5 at cycle 4 -> ignored; result is quotient=33, remainder=1. Back-to-back start in cycle 10 (50/5) -> quotient=10, remainder=0.
- Start 200/7, drive rst_n=0 at cycle 5 -> no done pulse, all outputs 0, state IDLE. The next start 9/2 -> quotient=4, remainder=1.
- Random 1000 unsigned pairs with nonzero divisor -> quotient*divisor+remainder==dividend and remainder<divisor.
